encoder_8: RTL and testbench
============================

// Module: encoder_8
// PURPOSE
//   Registered 8-to-3 one-hot encoder with validity and multi-hot error detection.
//   Converts an 8-bit one-hot request vector into a 3-bit binary index one cycle later.
//   Sits between request/decode logic and index-consuming datapaths.
//   Tracks illegal (multi-hot) inputs in a saturating error counter.
// PARAMETERS
//   CNT_W   8   width of saturating multi-hot error counter err_cnt
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      sample enable; 0 = hold all registered outputs
//   in       in   8      one-hot request vector; bit i set => index i
//   out      out  3      registered binary index
//   valid    out  1      registered; 1 when sampled in had at least one bit set
//   err      out  1      registered; 1 when sampled in had two or more bits set
//   err_cnt  out  CNT_W  saturating count of sampled multi-hot inputs
// BEHAVIOUR
//   - Reset (rst_n=0, async assert, sync release): out=3'b000, valid=0, err=0, err_cnt=0.
//   - Latency 1 cycle: outputs reflect in sampled at previous rising edge with en=1.
//   - en=0: out, valid, err, err_cnt all hold their values.
//   - Classification of sampled in (popcount p):
//       p==0 : out=3'b000, valid=0, err=0.
//       p==1 : out=index of set bit (bit0->000 ... bit7->111), valid=1, err=0.
//       p>=2 : valid=1, err=1; out per CONFIGURATION; err_cnt increments.
//   - err_cnt: +1 per enabled multi-hot sample; saturates at 2**CNT_W-1, no wrap.
//   - Outputs are never X/Z for any 8-bit input; out is fully defined in all cases.
//   - Reset asserted mid-operation clears all outputs immediately, no clock needed.
//   - Purely registered outputs; no combinational path from in to any output.
// CONFIGURATION
//   ENCODER8_PRIORITY_EN
//     defined  : multi-hot -> out = index of highest set bit (0001_0001 -> 3'b100).
//     undefined: multi-hot -> out = 3'b000.
//     err, valid, err_cnt behaviour identical in both builds.
// TESTING
//   1. rst_n=0 async mid-cycle -> out=000, valid=0, err=0, err_cnt=0 immediately.
//   2. en=1, in=00000001,00000010,...,10000000 -> next cycle out=000..111, valid=1, err=0.
//   3. en=1, in=00000000 -> next cycle out=000, valid=0, err=0.
//   4. en=1, in=00010001 -> valid=1, err=1, err_cnt+1; out=100 (PRIORITY_EN) else 000.
//   5. in=00000100 sampled, then en=0 with in=10000000 -> out stays 010, valid stays 1.
//   6. CNT_W=2, four multi-hot samples -> err_cnt 1,2,3,3 (saturates).

Source files
------------

// File: rtl/encoder_8.sv
// encoder_8: registered 8-to-3 one-hot encoder with valid, multi-hot error flag and saturating error count.
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset, synchronous release
//   en       in   1      sample enable; 0 holds every registered output
//   in       in   8      one-hot request vector
//   out      out  3      registered binary index of the sampled request
//   valid    out  1      sampled vector had at least one bit set
//   err      out  1      sampled vector had two or more bits set
//   err_cnt  out  CNT_W  saturating count of sampled multi-hot vectors
// Build option: define ENCODER8_PRIORITY_EN to report the highest set bit on
// multi-hot input; otherwise multi-hot input reports index 0.
module encoder_8 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [7:0]       in,
  output logic [2:0]       out,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);
  logic [3:0]       pop;
  logic [2:0]       hi_idx;
  logic [2:0]       multi_idx;
  logic             multi;
  logic [2:0]       out_d, out_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;
  logic [CNT_W-1:0] err_cnt_d, err_cnt_q;
  // hi_idx ends on the highest set bit, which is also the index of a lone bit
  always_comb begin
    pop = '0;
    hi_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (in[i]) begin
        pop = pop + 4'd1;
        hi_idx = 3'(i);
      end
    end
  end
`ifdef ENCODER8_PRIORITY_EN
  assign multi_idx = hi_idx;
`else
  assign multi_idx = 3'b000;
`endif
  assign multi = pop > 4'd1;
  always_comb begin
    out_d = en ? (multi ? multi_idx : hi_idx) : out_q;
    valid_d = en ? (pop != 4'd0) : valid_q;
    err_d = en ? multi : err_q;
    err_cnt_d = (en && multi && err_cnt_q != '1) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      out_q <= out_d;
      valid_q <= valid_d;
      err_q <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
  assign out = out_q;
  assign valid = valid_q;
  assign err = err_q;
  assign err_cnt = err_cnt_q;
endmodule

// File: tb/tb_encoder_8.sv
// tb_encoder_8: scoreboard bench for encoder_8 (default 8-bit counter and a 2-bit counter instance).
module tb_encoder_8;
`ifdef ENCODER8_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif
  typedef struct {
    logic [2:0] out;
    logic       valid;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] in = '0;
  logic [2:0] out, out2;
  logic       valid, valid2, err, err2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;
  exp_t       q[$];
  exp_t       m;
  int         n_chk = 0;
  int         n_fail = 0;
  encoder_8 dut (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .out(out), .valid(valid), .err(err), .err_cnt(err_cnt));
  encoder_8 #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .en(en), .in(in), .out(out2), .valid(valid2), .err(err2), .err_cnt(err_cnt2));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out"}, {5'b0, out}, {5'b0, e.out});
    chk({tag, ".valid"}, {7'b0, valid}, {7'b0, e.valid});
    chk({tag, ".err"}, {7'b0, err}, {7'b0, e.err});
    chk({tag, ".err_cnt"}, err_cnt, e.cnt);
    chk({tag, ".err_cnt2"}, {6'b0, err_cnt2}, {6'b0, e.cnt2});
  endtask
  // Drive one sample; expected out/valid/err are hand-computed by the caller.
  task automatic step(input logic e, input logic [7:0] v, input logic [2:0] eo, input logic ev, input logic ee);
    @(negedge clk);
    en = e;
    in = v;
    if (e) begin
      m.out = eo;
      m.valid = ev;
      m.err = ee;
      if (ee) begin
        if (m.cnt != 8'hff) m.cnt = m.cnt + 8'd1;
        if (m.cnt2 != 2'b11) m.cnt2 = m.cnt2 + 2'd1;
      end
    end
    q.push_back(m);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk_all("sample", e);
      end
    end
  end
  initial begin
    m = '{out: 3'b000, valid: 1'b0, err: 1'b0, cnt: 8'd0, cnt2: 2'd0};
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", m);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 8'b1 << i, 3'(i), 1'b1, 1'b0);
    step(1'b1, 8'b0000_0000, 3'b000, 1'b0, 1'b0);
    step(1'b1, 8'b0001_0001, PRIO ? 3'b100 : 3'b000, 1'b1, 1'b1);
    step(1'b1, 8'b0000_0100, 3'b010, 1'b1, 1'b0);
    step(1'b0, 8'b1000_0000, 3'b000, 1'b0, 1'b0);
    step(1'b0, 8'b1111_1111, 3'b000, 1'b0, 1'b0);
    step(1'b1, 8'b1111_1111, PRIO ? 3'b111 : 3'b000, 1'b1, 1'b1);
    step(1'b1, 8'b1000_0001, PRIO ? 3'b111 : 3'b000, 1'b1, 1'b1);
    step(1'b1, 8'b0000_0110, PRIO ? 3'b010 : 3'b000, 1'b1, 1'b1);
    step(1'b1, 8'b0100_0000, 3'b110, 1'b1, 1'b0);
    step(1'b0, 8'b0011_0000, 3'b000, 1'b0, 1'b0);
    step(1'b1, 8'b0000_1000, 3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expected samples never checked", q.size());
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m = '{out: 3'b000, valid: 1'b0, err: 1'b0, cnt: 8'd0, cnt2: 2'd0};
    chk_all("async_reset", m);
    @(posedge clk);
    #1;
    chk_all("reset_hold", m);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
